// File: rtl/i2c_script_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_script_seq_if
// Description : Command/response port between the script sequencer and a
//               byte-level I2C master.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_script_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;
    logic [7:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack, rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/i2c_script_seq.sv
`default_nettype none
// ============================================================================
// Module      : i2c_script_seq
// Description : Runs 9-bit I2C command scripts from a sync-read ROM and drives
//               a byte-level I2C master. Optional macro: I2CSEQ_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_script_seq #(
    parameter int AW          = 9,
    parameter int DELAY_TICKS = 50000,
    parameter int WDOG_TICKS  = 200000
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              start,
    input  wire  [AW-1:0]    start_addr,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [AW-1:0]    rom_ad,
    output logic             rom_ce,
    output logic             rom_oce,
    input  wire  [8:0]       rom_dout,
    i2c_script_seq_if.master i2c,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic [5:0]       rd_index
);

    localparam logic [2:0] c_OP_START = 3'd0;
    localparam logic [2:0] c_OP_STOP  = 3'd1;
    localparam logic [2:0] c_OP_WRITE = 3'd2;
    localparam logic [2:0] c_OP_RDACK = 3'd3;
    localparam logic [2:0] c_OP_RDNAK = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_ROMWAIT = 4'd2,
        S_DECODE  = 4'd3,
        S_ISSUE   = 4'd4,
        S_RSP     = 4'd5,
        S_DELAY   = 4'd6,
        S_DONE    = 4'd7,
        S_ERR     = 4'd8
    } state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_ptr;
    logic          r_wrap;
    logic [8:0]    r_word;
    logic [2:0]    r_cmd_op;
    logic [7:0]    r_cmd_data;
    logic          r_nack_stop;
    logic [31:0]   r_dly_cnt;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;
    logic [5:0]    r_rd_index;
    logic          w_wdog_expired;
    logic          w_is_read;

    assign w_is_read = (r_cmd_op == c_OP_RDACK) || (r_cmd_op == c_OP_RDNAK);

`ifdef I2CSEQ_WATCHDOG_EN
    logic [31:0] r_wdog;

    always_ff @(posedge clk) begin
        if (!reset_n || r_state != S_RSP) begin
            r_wdog <= 32'd0;
        end else begin
            r_wdog <= r_wdog + 32'd1;
        end
    end

    assign w_wdog_expired = (r_state == S_RSP) && (r_wdog == 32'(WDOG_TICKS - 1));
`else
    assign w_wdog_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_FETCH;
            // A pointer that wrapped past the top of the ROM never refetches word 0
            S_FETCH:   w_next = r_wrap ? S_ERR : S_ROMWAIT;
            S_ROMWAIT: w_next = S_DECODE;
            S_DECODE: begin
                if (!r_word[8]) begin
                    w_next = S_ISSUE;
                end else begin
                    case (r_word[7:6])
                        2'b00: begin
                            case (r_word[1:0])
                                2'd0:    w_next = S_FETCH;
                                2'd3:    w_next = S_DONE;
                                default: w_next = S_ISSUE;
                            endcase
                        end
                        2'b01:   w_next = S_ISSUE;
                        2'b10:   w_next = (r_word[5:0] == 6'd0) ? S_FETCH : S_DELAY;
                        default: w_next = S_ERR;
                    endcase
                end
            end
            S_ISSUE:   if (i2c.cmd_ready) w_next = S_RSP;
            S_RSP: begin
                if (i2c.rsp_valid) begin
                    if (r_nack_stop) begin
                        w_next = S_ERR;
                    end else if (r_cmd_op == c_OP_WRITE && i2c.rsp_nack) begin
                        w_next = S_ISSUE;
                    end else begin
                        w_next = S_FETCH;
                    end
                end else if (w_wdog_expired) begin
                    w_next = S_ERR;
                end
            end
            S_DELAY:   if (r_dly_cnt == 32'd0) w_next = S_FETCH;
            S_DONE:    w_next = S_IDLE;
            S_ERR:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr       <= '0;
            r_wrap      <= 1'b0;
            r_word      <= 9'd0;
            r_cmd_op    <= 3'd0;
            r_cmd_data  <= 8'd0;
            r_nack_stop <= 1'b0;
            r_dly_cnt   <= 32'd0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= 8'd0;
            r_rd_index  <= 6'd0;
        end else begin
            r_rd_valid <= 1'b0;
            if (r_rd_valid) begin
                r_rd_index <= r_rd_index + 6'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr       <= start_addr;
                        r_wrap      <= 1'b0;
                        r_nack_stop <= 1'b0;
                        r_rd_index  <= 6'd0;
                    end
                end
                S_ROMWAIT: r_word <= rom_dout;
                S_DECODE: begin
                    r_ptr      <= r_ptr + AW'(1);
                    r_wrap     <= &r_ptr;
                    r_cmd_data <= 8'd0;
                    if (!r_word[8]) begin
                        r_cmd_op   <= c_OP_WRITE;
                        r_cmd_data <= r_word[7:0];
                    end else if (r_word[7:6] == 2'b00) begin
                        r_cmd_op <= (r_word[1:0] == 2'd2) ? c_OP_STOP : c_OP_START;
                    end else if (r_word[7:6] == 2'b01) begin
                        r_cmd_op <= r_word[5] ? c_OP_RDNAK : c_OP_RDACK;
                    end
                    r_dly_cnt <= 32'(r_word[5:0]) * 32'(DELAY_TICKS) - 32'd1;
                end
                S_RSP: begin
                    if (i2c.rsp_valid) begin
                        // A NACKed write is followed by a STOP before the abort
                        if (!r_nack_stop && r_cmd_op == c_OP_WRITE && i2c.rsp_nack) begin
                            r_nack_stop <= 1'b1;
                            r_cmd_op    <= c_OP_STOP;
                            r_cmd_data  <= 8'd0;
                        end
                        if (w_is_read) begin
                            r_rd_valid <= 1'b1;
                            r_rd_data  <= i2c.rsp_data;
                        end
                    end
                end
                S_DELAY: r_dly_cnt <= r_dly_cnt - 32'd1;
                default: ;
            endcase
        end
    end

    assign busy          = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERR);
    assign done          = (r_state == S_DONE);
    assign error         = (r_state == S_ERR);
    assign rom_ad        = r_ptr;
    assign rom_ce        = (r_state == S_FETCH) && !r_wrap;
    assign rom_oce       = 1'b1;
    assign i2c.cmd_valid = (r_state == S_ISSUE);
    assign i2c.cmd_op    = r_cmd_op;
    assign i2c.cmd_data  = r_cmd_data;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = r_rd_data;
    assign rd_index      = r_rd_index;

endmodule
`default_nettype wire
